// File: rtl/shift_add_multiplier_if.sv
// Operand/result handshake bundle for shift_add_multiplier.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier, one partial product per cycle.
// Optional SHIFT_ADD_MULT_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are zero.
module shift_add_multiplier #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input logic                    clk,
    input logic                    rst_n,
    shift_add_multiplier_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] product_q;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               last;

    always_comb acc_nxt = acc + (mplier[0] ? mcand : '0);

`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    // Stop once no set multiplier bits remain after this iteration.
    assign last = (mplier[WIDTH-1:1] == '0) || (cnt == CNT_W'(WIDTH - 1));
`else
    assign last = (cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        bus.product   = product_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else begin
            if (state == IDLE && bus.in_valid) begin
                mcand  <= {{WIDTH{1'b0}}, bus.a};
                mplier <= bus.b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
                // Result register only moves on DONE entry, so it holds across IDLE.
                if (last) product_q <= acc_nxt;
            end
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: WIDTH=4 and WIDTH=8 instances against a latency/product model.
module tb_shift_add_multiplier;
    localparam int W[2] = '{4, 8};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        drv_in_valid[2];
    logic        drv_out_ready[2];
    logic [15:0] drv_a[2];
    logic [15:0] drv_b[2];
    logic        obs_in_ready[2];
    logic        obs_out_valid[2];
    logic        obs_busy[2];
    logic [31:0] obs_product[2];

    int n_tests = 0;
    int n_fail  = 0;

    shift_add_multiplier_if #(.WIDTH(4)) if4 ();
    shift_add_multiplier_if #(.WIDTH(8)) if8 ();

    shift_add_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    shift_add_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    assign if4.in_valid  = drv_in_valid[0];
    assign if4.a         = drv_a[0][3:0];
    assign if4.b         = drv_b[0][3:0];
    assign if4.out_ready = drv_out_ready[0];
    assign if8.in_valid  = drv_in_valid[1];
    assign if8.a         = drv_a[1][7:0];
    assign if8.b         = drv_b[1][7:0];
    assign if8.out_ready = drv_out_ready[1];

    assign obs_in_ready[0]  = if4.in_ready;
    assign obs_out_valid[0] = if4.out_valid;
    assign obs_busy[0]      = if4.busy;
    assign obs_product[0]   = 32'(if4.product);
    assign obs_in_ready[1]  = if8.in_ready;
    assign obs_out_valid[1] = if8.out_valid;
    assign obs_busy[1]      = if8.busy;
    assign obs_product[1]   = 32'(if8.product);

    // Expected cycles from accept to out_valid.
    function automatic int exp_lat(input int w, input logic [15:0] bv);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        int l = 1;
        for (int i = 0; i < w; i++) if (bv[i]) l = i + 1;
        return l;
`else
        return w;
`endif
    endfunction

    // Model: 0 idle, 1 computing, 2 result waiting.
    int          m_st[2]   = '{0, 0};
    int          m_rem[2]  = '{0, 0};
    logic [31:0] m_res[2]  = '{32'd0, 32'd0};
    logic [31:0] m_prod[2] = '{32'd0, 32'd0};

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_st[d]   <= 0;
                m_rem[d]  <= 0;
                m_prod[d] <= 32'd0;
            end else begin
                case (m_st[d])
                    0: if (drv_in_valid[d]) begin
                        m_st[d]  <= 1;
                        m_rem[d] <= exp_lat(W[d], drv_b[d]);
                        m_res[d] <= 32'(drv_a[d]) * 32'(drv_b[d]);
                    end
                    1: begin
                        m_rem[d] <= m_rem[d] - 1;
                        if (m_rem[d] == 1) begin
                            m_st[d]   <= 2;
                            m_prod[d] <= m_res[d];
                        end
                    end
                    default: if (drv_out_ready[d]) m_st[d] <= 0;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full operation on DUT d; optional result stall with in_valid pokes.
    task automatic do_op(input int d, input int av, input int bv, input int stall,
                         input bit poke, output int lat, output logic [31:0] prod);
        drv_out_ready[d] = (stall == 0);
        drv_a[d]         = 16'(av);
        drv_b[d]         = 16'(bv);
        drv_in_valid[d]  = 1'b1;
        chk("in_ready_before_accept", 32'(obs_in_ready[d]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drv_in_valid[d] = 1'b0;
        lat = 0;
        while (!obs_out_valid[d] && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("out_valid_seen", 32'(obs_out_valid[d]), 32'd1);
        prod = obs_product[d];
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                drv_in_valid[d] = 1'b1;
                drv_a[d]        = 16'd1;
                drv_b[d]        = 16'd1;
            end
            @(posedge clk);
            @(negedge clk);
            chk("stall_out_valid", 32'(obs_out_valid[d]), 32'd1);
            chk("stall_product", obs_product[d], prod);
            if (poke) chk("stall_in_ready", 32'(obs_in_ready[d]), 32'd0);
        end
        drv_in_valid[d]  = 1'b0;
        drv_out_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_out_ready[d] = 1'b0;
        chk("in_ready_after_retire", 32'(obs_in_ready[d]), 32'd1);
        chk("product_kept", obs_product[d], prod);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] prod;
        int          av;
        int          bv;
        int          order[256];

        for (int d = 0; d < 2; d++) begin
            drv_in_valid[d]  = 1'b0;
            drv_out_ready[d] = 1'b0;
            drv_a[d]         = 16'd0;
            drv_b[d]         = 16'd0;
        end

        fork
            forever begin
                @(negedge clk);
                for (int d = 0; d < 2; d++) begin
                    chk("mon_in_ready",  32'(obs_in_ready[d]),  32'(m_st[d] == 0));
                    chk("mon_out_valid", 32'(obs_out_valid[d]), 32'(m_st[d] == 2));
                    chk("mon_busy",      32'(obs_busy[d]),      32'(m_st[d] != 0));
                    chk("mon_product",   obs_product[d],        m_prod[d]);
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_in_ready",  32'(obs_in_ready[0]),  32'd1);
        chk("reset_out_valid", 32'(obs_out_valid[0]), 32'd0);
        chk("reset_busy",      32'(obs_busy[0]),      32'd0);
        chk("reset_product",   obs_product[0],        32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 15*15 with consumer always ready
        do_op(0, 15, 15, 0, 1'b0, lat, prod);
        chk("t1_product", prod, 32'hE1);
        chk("t1_latency", 32'(lat), 32'd4);

        // 9*6 with a 5-cycle consumer stall and ignored operand pokes
        do_op(0, 9, 6, 5, 1'b1, lat, prod);
        chk("t2_product", prod, 32'h36);

        // Reset in the middle of 7*13
        drv_a[0] = 16'd7; drv_b[0] = 16'd13; drv_in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t3_rst_in_ready",  32'(obs_in_ready[0]),  32'd1);
        chk("t3_rst_out_valid", 32'(obs_out_valid[0]), 32'd0);
        chk("t3_rst_busy",      32'(obs_busy[0]),      32'd0);
        chk("t3_rst_product",   obs_product[0],        32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_no_out_valid", 32'(obs_out_valid[0]), 32'd0);
        end
        do_op(0, 3, 5, 0, 1'b0, lat, prod);
        chk("t3_product", prod, 32'h0F);

        // All 256 WIDTH=4 pairs in shuffled order with random stalls
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(0, i));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            av = order[i] / 16;
            bv = order[i] % 16;
            do_op(0, av, bv, int'($urandom_range(0, 3)), 1'b0, lat, prod);
            chk("t4_product", prod, 32'(av * bv));
            chk("t4_latency", 32'(lat), 32'(exp_lat(4, 16'(bv))));
        end

        // WIDTH=8 corner values
        do_op(1, 255, 255, 0, 1'b0, lat, prod);
        chk("t5_product_max", prod, 32'hFE01);
        chk("t5_latency_max", 32'(lat), 32'd8);
        do_op(1, 0, 200, 1, 1'b0, lat, prod);
        chk("t5_product_zero", prod, 32'h0000);
        chk("t5_latency_zero", 32'(lat), 32'd8);

`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        do_op(1, 77, 0, 0, 1'b0, lat, prod);
        chk("t6_b0_product", prod, 32'd0);
        chk("t6_b0_latency", 32'(lat), 32'd1);
        do_op(1, 77, 1, 0, 1'b0, lat, prod);
        chk("t6_b1_product", prod, 32'd77);
        chk("t6_b1_latency", 32'(lat), 32'd1);
        do_op(1, 3, 16, 0, 1'b0, lat, prod);
        chk("t6_b10_product", prod, 32'h30);
        chk("t6_b10_latency", 32'(lat), 32'd5);
        do_op(1, 2, 128, 0, 1'b0, lat, prod);
        chk("t6_b80_product", prod, 32'h100);
        chk("t6_b80_latency", 32'(lat), 32'd8);
`else
        do_op(1, 77, 0, 0, 1'b0, lat, prod);
        chk("t6_b0_product", prod, 32'd0);
        chk("t6_b0_latency", 32'(lat), 32'd8);
        do_op(1, 3, 16, 0, 1'b0, lat, prod);
        chk("t6_b10_product", prod, 32'h30);
        chk("t6_b10_latency", 32'(lat), 32'd8);
`endif

        // Random WIDTH=8 operands
        for (int i = 0; i < 40; i++) begin
            av = int'($urandom_range(0, 255));
            bv = int'($urandom_range(0, 255));
            do_op(1, av, bv, int'($urandom_range(0, 2)), 1'b0, lat, prod);
            chk("t7_product", prod, 32'(av * bv));
            chk("t7_latency", 32'(lat), 32'(exp_lat(8, 16'(bv))));
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
